// File: rtl/superbug_pkg.sv
// Shared constants and types for the Super Bug input-port responder.
package superbug_pkg;

  // Bit positions of the cabinet switches within Sw_n
  localparam int SW_COIN1    = 0;
  localparam int SW_COIN2    = 1;
  localparam int SW_START    = 2;
  localparam int SW_TRAKSEL  = 3;
  localparam int SW_SELFTEST = 4;
  localparam int SW_SLAM     = 5;
  localparam int SW_GAS      = 6;
  localparam int SW_SPARE    = 7;

  // Source of Dout[6] during an In1 read, selected by Adr
  typedef enum logic [2:0] {
    SEL_STEER_FLAG = 3'd0,
    SEL_STEER_DIR  = 3'd1,
    SEL_CRASH      = 3'd2,
    SEL_SKID       = 3'd3,
    SEL_GEAR1      = 3'd4,
    SEL_GEAR2      = 3'd5,
    SEL_GEAR3      = 3'd6,
    SEL_ONE        = 3'd7
  } in1_sel_e;

  // Read data when no strobe is active (open bus reads as ones)
  localparam logic [7:0] DOUT_IDLE = 8'hFF;

  // Quadrature phase, encoded as {A,B}
  typedef enum logic [1:0] {
    QD_00 = 2'b00,
    QD_01 = 2'b01,
    QD_11 = 2'b11,
    QD_10 = 2'b10
  } quad_phase_e;

  // Phase that follows ph when the wheel turns right (00->01->11->10->00)
  function automatic quad_phase_e quad_next_right(input quad_phase_e ph);
    quad_phase_e nxt;
    case (ph)
      QD_00:   nxt = QD_01;
      QD_01:   nxt = QD_11;
      QD_11:   nxt = QD_10;
      QD_10:   nxt = QD_00;
      default: nxt = QD_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Steering-wheel quadrature decoder: flags one valid Gray-code step per cycle
// and reports its direction. Two-bit jumps and no-change cycles are ignored.
//
// state | meaning
// QD_00 | last sampled {A,B} = 00
// QD_01 | last sampled {A,B} = 01
// QD_11 | last sampled {A,B} = 11
// QD_10 | last sampled {A,B} = 10
module quad_decoder
  import superbug_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic step,
  output logic dir
);

  quad_phase_e state_q;
  quad_phase_e state_d;

  // Remember the previous synchronized phase
  always_ff @(posedge clk) begin
    if (reset) state_q <= QD_00;
    else       state_q <= state_d;
  end

  // Next state is simply the current phase; classify the transition
  always_comb begin
    state_d = quad_phase_e'({a, b});
    step    = 1'b0;
    dir     = 1'b0;
    if (state_d == quad_next_right(state_q)) begin
      step = 1'b1;
      dir  = 1'b1;
    end else if (state_q == quad_next_right(state_d)) begin
      step = 1'b1;
      dir  = 1'b0;
    end
  end

endmodule

// File: rtl/superbug_input_ports.sv
// Super Bug input-port responder: synchronizes cabinet inputs, keeps the
// steering/crash/skid flags and returns registered read data for the
// In1 (switch) and Opt (DIP) read strobes.
module superbug_input_ports
  import superbug_pkg::*;
#(
  parameter int SYNC_STAGES = 2
)
(
  input  logic       Clk6,
  input  logic       Reset,
  input  logic [2:0] Adr,
  input  logic       In1_n,
  input  logic       Opt_n,
  input  logic       SteerReset_n,
  input  logic       CrashReset_n,
  input  logic       SkidReset_n,
  input  logic       CrashIn,
  input  logic       SkidIn,
  input  logic [7:0] Sw_n,
  input  logic [2:0] Gear_n,
  input  logic       SteerA,
  input  logic       SteerB,
  input  logic [7:0] Dip,
  output logic [7:0] Dout,
  output logic       CrashFlag,
  output logic       SkidFlag
);

  localparam int SYNC_W = 13;

  logic [SYNC_W-1:0] async_in;
  logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
  logic [7:0]        sw_s;
  logic [2:0]        gear_s;
  logic              steer_a_s;
  logic              steer_b_s;

  logic       step;
  logic       step_right;
  logic       steer_flag;
  logic       steer_dir;
  logic       crash_flag;
  logic       skid_flag;
  in1_sel_e   in1_sel;
  logic       in1_bit6;
  logic [7:0] dout_next;

  assign async_in = {SteerB, SteerA, Gear_n, Sw_n};

  // Synchronizer chain for all asynchronous cabinet inputs
  always_ff @(posedge Clk6) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sw_s      = sync_q[SYNC_STAGES-1][7:0];
  assign gear_s    = sync_q[SYNC_STAGES-1][10:8];
  assign steer_a_s = sync_q[SYNC_STAGES-1][11];
  assign steer_b_s = sync_q[SYNC_STAGES-1][12];

  quad_decoder u_quad_decoder (
    .clk   (Clk6),
    .reset (Reset),
    .a     (steer_a_s),
    .b     (steer_b_s),
    .step  (step),
    .dir   (step_right)
  );

  // Steering flag/direction: a CPU clear wins over a same-cycle step
  always_ff @(posedge Clk6) begin
    if (Reset || !SteerReset_n) begin
      steer_flag <= 1'b0;
      steer_dir  <= 1'b0;
    end else if (step) begin
      steer_flag <= 1'b1;
      steer_dir  <= step_right;
    end
  end

  // Crash flag: set by collision pulse, held until the CPU clears it
  always_ff @(posedge Clk6) begin
    if (Reset || !CrashReset_n) crash_flag <= 1'b0;
    else if (CrashIn)           crash_flag <= 1'b1;
  end

  // Skid flag: set by skid pulse, held until the CPU clears it
  always_ff @(posedge Clk6) begin
    if (Reset || !SkidReset_n) skid_flag <= 1'b0;
    else if (SkidIn)           skid_flag <= 1'b1;
  end

  assign CrashFlag = crash_flag;
  assign SkidFlag  = skid_flag;
  assign in1_sel   = in1_sel_e'(Adr);

  // Read-data mux; In1 wins if both strobes are (illegally) low
  always_comb begin
    dout_next = DOUT_IDLE;
    in1_bit6  = 1'b1;
    case (in1_sel)
      SEL_STEER_FLAG: in1_bit6 = ~steer_flag;
      SEL_STEER_DIR:  in1_bit6 = steer_dir;
      SEL_CRASH:      in1_bit6 = ~crash_flag;
      SEL_SKID:       in1_bit6 = ~skid_flag;
      SEL_GEAR1:      in1_bit6 = gear_s[0];
      SEL_GEAR2:      in1_bit6 = gear_s[1];
      SEL_GEAR3:      in1_bit6 = gear_s[2];
      SEL_ONE:        in1_bit6 = 1'b1;
      default:        in1_bit6 = 1'b1;
    endcase
    if (!In1_n) begin
      dout_next = {sw_s[Adr], in1_bit6, 6'b111111};
    end else if (!Opt_n) begin
      dout_next = {6'b111111, Dip[{Adr[1:0], 1'b1}], Dip[{Adr[1:0], 1'b0}]};
    end
  end

  // Registered read data so it is stable across the CPU strobe
  always_ff @(posedge Clk6) begin
    if (Reset) Dout <= DOUT_IDLE;
    else       Dout <= dout_next;
  end

endmodule
